// File: rtl/regfile_write_sequencer_pkg.sv
// Shared register-file constants, sequencer state type and init-value helper
// for the writeback-side write-port sequencer.
package regfile_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned REG_COUNT = 32;

  typedef enum logic {ST_INIT, ST_RUN} wseq_state_t;

  // Value written to register idx during the post-reset init walk.
  function automatic logic [XLEN-1:0] init_value(input logic [ADDR_W-1:0] idx,
                                                 input bit              zero_ext);
    if (zero_ext) return XLEN'(idx);
    return '0;
  endfunction

endpackage

// File: rtl/regfile_write_sequencer_if.sv
// Writeback requester bundle plus register-file write port, with the
// requester/register-file side as master and the sequencer as slave.
interface regfile_write_sequencer_if #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 5
);
  localparam int unsigned GID_W = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_rd;
  logic [NREQ*XLEN-1:0]   req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   rf_we;
  logic [ADDR_W-1:0]      rf_rd;
  logic [XLEN-1:0]        rf_wdata;
  logic [GID_W-1:0]       grant_id;
  logic                   init_done;

  modport master (
    output req_valid, req_rd, req_data,
    input  req_ready, rf_we, rf_rd, rf_wdata, grant_id, init_done
  );

  modport slave (
    input  req_valid, req_rd, req_data,
    output req_ready, rf_we, rf_rd, rf_wdata, grant_id, init_done
  );

endinterface

// File: rtl/regfile_write_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i
// (with wrap) wins; the pointer itself lives in the parent.
module rr_arbiter #(
  parameter  int unsigned NREQ  = 2,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [NREQ-1:0] rot;

  always_comb begin
    // Rotate so bit 0 is the requester at ptr_i, then take the lowest set bit.
    rot   = NREQ'({req_i, req_i} >> ptr_i);
    any_o = 1'b0;
    idx_o = '0;
    gnt_o = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      if (!any_o && rot[off]) begin
        any_o = 1'b1;
        idx_o = IDX_W'((32'(ptr_i) + off) % NREQ);
      end
    end
    if (any_o) gnt_o = NREQ'(1) << idx_o;
  end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Owns the register file write port: init walk after reset, then round-robin
// arbitration of writeback requesters with a registered 1-cycle write.
module regfile_write_sequencer
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned INIT_MODE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  regfile_write_sequencer_if.slave   bus
);

  localparam int unsigned GID_W = $clog2(NREQ);

  wseq_state_t       state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic [GID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic [GID_W-1:0]  grant_id_q, grant_id_d;

  logic [NREQ-1:0]   gnt;
  logic [GID_W-1:0]  win_idx;
  logic              win_any;
  logic              run;
  logic              hs;
  logic [ADDR_W-1:0] win_rd;
  logic [XLEN-1:0]   win_data;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  assign run = (state_q == ST_RUN);

  // Ready is masked by reset so a handshake can never coincide with reset.
  assign bus.req_ready = (run && !reset) ? gnt : '0;
  assign hs            = run && !reset && win_any;

  always_comb begin
    win_rd   = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == GID_W'(i)) begin
        win_rd   = bus.req_rd[i*ADDR_W +: ADDR_W];
        win_data = bus.req_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    grant_id_d = grant_id_q;
    unique case (state_q)
      ST_INIT: begin
        rf_we_d    = 1'b1;
        rf_rd_d    = init_cnt_q;
        rf_wdata_d = init_value(init_cnt_q, INIT_MODE != 0);
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == ADDR_W'(REG_COUNT - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (hs) begin
          rr_ptr_d = (win_idx == GID_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          // x0 writes are accepted but never reach the register file.
          if (win_rd != '0) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = win_rd;
            rf_wdata_d = win_data;
            grant_id_d = win_idx;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign bus.rf_we     = rf_we_q;
  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.init_done = run;

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Scoreboard bench for regfile_write_sequencer: a cycle-level requester model
// predicts ready and queues expected register-file writes for a monitor.
module tb_regfile_write_sequencer;
  import regfile_pkg::*;

  localparam int unsigned NR = 2;

  typedef struct {
    int unsigned       cyc;
    logic [ADDR_W-1:0] rd;
    logic [XLEN-1:0]   data;
    int                gid;
    bit                init;
  } exp_t;

  logic        clk;
  logic        reset;
  int unsigned cyc;
  int unsigned n_cmp;
  int unsigned n_bad;
  exp_t        q[$];

  bit                pend[NR];
  logic [ADDR_W-1:0] prd[NR];
  logic [XLEN-1:0]   pdat[NR];

  bit          m_run;
  int unsigned init_left;
  int unsigned ptr;

  regfile_write_sequencer_if #(.NREQ(NR), .XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();
  regfile_write_sequencer_if #(.NREQ(NR), .XLEN(XLEN), .ADDR_W(ADDR_W)) bus0 ();

  regfile_write_sequencer #(.NREQ(NR), .INIT_MODE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  regfile_write_sequencer #(.NREQ(NR), .INIT_MODE(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input int unsigned i, input logic [ADDR_W-1:0] rd, input logic [XLEN-1:0] d);
    if (!pend[i]) begin
      pend[i] = 1'b1;
      prd[i]  = rd;
      pdat[i] = d;
    end
  endtask

  // One clock: drive inputs after the edge, check ready mid-cycle, advance model.
  task automatic step(input bit rst_in);
    int          win;
    logic [NR-1:0] exp_ready;
    @(posedge clk);
    #1;
    reset = rst_in;
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]                 = pend[i];
      bus.req_rd[i*ADDR_W +: ADDR_W]   = prd[i];
      bus.req_data[i*XLEN +: XLEN]     = pdat[i];
    end
    @(negedge clk);
    win = -1;
    if (m_run && !rst_in) begin
      for (int off = 0; off < NR; off++) begin
        int j;
        j = (int'(ptr) + off) % NR;
        if (win < 0 && pend[j]) win = j;
      end
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    chk("init_done", 64'(bus.init_done), 64'(m_run));

    if (rst_in) begin
      m_run     = 1'b0;
      init_left = REG_COUNT;
      ptr       = 0;
    end else if (!m_run) begin
      int unsigned idx;
      idx = REG_COUNT - init_left;
      q.push_back('{cyc: cyc + 1, rd: ADDR_W'(idx), data: XLEN'(idx), gid: -1, init: 1'b1});
      init_left--;
      if (init_left == 0) m_run = 1'b1;
    end else if (win >= 0) begin
      if (prd[win] != '0)
        q.push_back('{cyc: cyc + 1, rd: prd[win], data: pdat[win], gid: win, init: 1'b0});
      ptr       = (win + 1) % NR;
      pend[win] = 1'b0;
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rf_we === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_rf_we", 64'(bus.rf_we), 64'(0));
        end else begin
          e = q.pop_front();
          chk("write_cycle", 64'(cyc), 64'(e.cyc));
          chk("rf_rd", 64'(bus.rf_rd), 64'(e.rd));
          chk("rf_wdata", bus.rf_wdata, e.data);
          if (!e.init) begin
            chk("grant_id", 64'(bus.grant_id), 64'(e.gid));
          end else begin
            chk("zinit_rf_we", 64'(bus0.rf_we), 64'(1));
            chk("zinit_rf_rd", 64'(bus0.rf_rd), 64'(e.rd));
            chk("zinit_rf_wdata", bus0.rf_wdata, 64'(0));
          end
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        chk("missing_rf_we", 64'(bus.rf_we), 64'(1));
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    m_run = 1'b0;
    init_left = REG_COUNT;
    ptr = 0;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0;
      prd[i]  = '0;
      pdat[i] = '0;
    end
    bus.req_valid  = '0;
    bus.req_rd     = '0;
    bus.req_data   = '0;
    bus0.req_valid = '0;
    bus0.req_rd    = '0;
    bus0.req_data  = '0;

    repeat (3) step(1'b1);

    // Init walk with a requester already waiting: ready must stay low until run.
    issue(0, 5'd7, 64'h1234_5678);
    repeat (34) step(1'b0);

    // Single write.
    issue(0, 5'd5, 64'hDEAD);
    repeat (2) step(1'b0);

    // Continuous contention alternates grants.
    for (int k = 0; k < 8; k++) begin
      issue(0, 5'd3, 64'h300 + 64'(k));
      issue(1, 5'd4, 64'h400 + 64'(k));
      step(1'b0);
    end
    repeat (3) step(1'b0);

    // x0 write is accepted and dropped, then req0 wins contention.
    issue(1, 5'd0, 64'hFF);
    step(1'b0);
    issue(0, 5'd9, 64'hA0);
    issue(1, 5'd10, 64'hB0);
    repeat (3) step(1'b0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      bit r;
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          logic [ADDR_W-1:0] rd;
          rd = ($urandom_range(0, 4) == 0) ? '0 : ADDR_W'($urandom_range(1, REG_COUNT - 1));
          issue(i, rd, {$urandom(), $urandom()});
        end
      end
      r = ($urandom_range(0, 79) == 0);
      step(r);
    end

    // Reset mid init walk at init_cnt=10.
    step(1'b1);
    repeat (10) step(1'b0);
    step(1'b1);
    repeat (40) step(1'b0);

    // Reset in a cycle where both requesters are waiting.
    issue(0, 5'd12, 64'hC0);
    issue(1, 5'd13, 64'hD0);
    step(1'b1);
    repeat (40) step(1'b0);

    repeat (5) step(1'b0);
    chk("queue_drained", 64'(q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
